wr_dec_scoreboard: RTL

- Parametrised successor to the register-file write-enable decoder.
- Decodes the writeback destination into a registered one-hot write-enable vector for the register file.
- Also keeps a per-register pending-write (busy) scoreboard, set at issue and cleared at writeback, so the decode stage can detect RAW/WAW hazards.
- Sits between the decode/issue stage and the register file in the 64-bit pipeline. Generates the stall request and a saturating stall-cycle counter.

---
 rtl/wrdec_pkg.sv | 17 +
 rtl/wr_onehot_dec.sv | 32 +++
 rtl/wr_dec_scoreboard.sv | 115 +++++++++++
 3 files changed

// File: rtl/wrdec_pkg.sv
// ============================================================================
// Module      : wrdec_pkg
// Description : Shared defaults and types for the write-enable decoder and
//               pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wrdec_pkg;
   localparam int ADDR_W_DEF   = 5;
   localparam int ZERO_REG_DEF = 31;

   typedef logic [ADDR_W_DEF-1:0]      reg_addr_t;
   typedef logic [2**ADDR_W_DEF-1:0]   reg_vec_t;
endpackage

`default_nettype wire

// File: rtl/wr_onehot_dec.sv
// ============================================================================
// Module      : wr_onehot_dec
// Description : Combinational enable + address -> one-hot decoder; the
//               hardwired-zero register bit is always masked off.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_onehot_dec
   import wrdec_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF
)(
   input  logic                 en,
   input  logic [ADDR_W-1:0]    addr,
   output logic [2**ADDR_W-1:0] onehot
);

   localparam int NUM_REGS = 2**ADDR_W;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
      if (i == ZERO_REG) begin : g_zero
         assign onehot[i] = 1'b0;
      end else begin : g_live
         assign onehot[i] = en & (addr == ADDR_W'(i));
      end
   end

endmodule

`default_nettype wire

// File: rtl/wr_dec_scoreboard.sv
// ============================================================================
// Module      : wr_dec_scoreboard
// Description : Registered one-hot register-file write enable plus a
//               pending-write scoreboard with issue stall and stall counter.
//               Optional macro WRDEC_WB_BYPASS_EN lets a same-cycle writeback
//               release the hazard on its register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_dec_scoreboard
   import wrdec_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = ZERO_REG_DEF,
   parameter int CNT_W    = 16
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 iss_valid,
   input  logic                 iss_wen,
   input  logic [ADDR_W-1:0]    iss_rd,
   input  logic [ADDR_W-1:0]    iss_rn,
   input  logic [ADDR_W-1:0]    iss_rm,
   input  logic                 wb_valid,
   input  logic [ADDR_W-1:0]    wb_rd,
   output logic [2**ADDR_W-1:0] rf_wen,
   output logic [2**ADDR_W-1:0] busy_vec,
   output logic                 stall,
   output logic                 iss_accept,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic                 err_wb_idle
);

   localparam int                NUM_REGS   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);
   localparam logic [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};

   logic [NUM_REGS-1:0] r_busy;
   logic [NUM_REGS-1:0] r_rf_wen;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic                r_err;

   logic [NUM_REGS-1:0] w_set_vec;
   logic [NUM_REGS-1:0] w_wb_vec;
   logic [NUM_REGS-1:0] w_eff_busy;
   logic                w_hz_a;
   logic                w_hz_b;
   logic                w_hz_d;
   logic                w_stall;
   logic                w_accept;
   logic                w_wb_idle;

   wr_onehot_dec #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_set_dec (
      .en     (w_accept & iss_wen),
      .addr   (iss_rd),
      .onehot (w_set_vec)
   );

   wr_onehot_dec #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_wb_dec (
      .en     (wb_valid),
      .addr   (wb_rd),
      .onehot (w_wb_vec)
   );

`ifdef WRDEC_WB_BYPASS_EN
   // A writeback landing this cycle no longer blocks its consumers.
   assign w_eff_busy = r_busy & ~w_wb_vec;
`else
   assign w_eff_busy = r_busy;
`endif

   assign w_hz_a   = w_eff_busy[iss_rn] & (iss_rn != c_zero_reg);
   assign w_hz_b   = w_eff_busy[iss_rm] & (iss_rm != c_zero_reg);
   assign w_hz_d   = iss_wen & w_eff_busy[iss_rd] & (iss_rd != c_zero_reg);
   assign w_stall  = iss_valid & (w_hz_a | w_hz_b | w_hz_d);
   assign w_accept = iss_valid & ~w_stall;

   assign w_wb_idle = wb_valid & ~r_busy[wb_rd] & (wb_rd != c_zero_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy      <= '0;
         r_rf_wen    <= '0;
         r_stall_cnt <= '0;
         r_err       <= 1'b0;
      end else begin
         // Set applied after clear so a new writer to the same register stays pending.
         r_busy   <= (r_busy & ~w_wb_vec) | w_set_vec;
         r_rf_wen <= w_wb_vec;
         if (w_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_wb_idle) begin
            r_err <= 1'b1;
         end
      end
   end

   assign rf_wen      = r_rf_wen;
   assign busy_vec    = r_busy;
   assign stall       = w_stall;
   assign iss_accept  = w_accept;
   assign stall_cnt   = r_stall_cnt;
   assign err_wb_idle = r_err;

endmodule

`default_nettype wire
